hex_scan_display: RTL and testbench



---
 rtl/hex_scan_if.sv | 22 ++
 rtl/hex_scan_display.sv | 148 ++++++++++++++
 tb/tb_hex_scan_display.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hex_scan_if.sv
// Display-side bus for hex_scan_display: shadow-load inputs and the
// registered segment/digit/frame outputs.
interface hex_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    load;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   digit_n;
    logic                    frame;

    modport master (
        output value, blank_mask, load,
        input  seg_n, digit_n, frame
    );

    modport slave (
        input  value, blank_mask, load,
        output seg_n, digit_n, frame
    );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed N-digit common-anode seven-segment scanner with shadow
// registers, per-slot blanking and mask. Optional HEX_SCAN_LZ_BLANK_EN adds leading-zero suppression.
module hex_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic     clk,
    input  logic     reset,
    hex_scan_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = $clog2(CLK_DIV);
    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(CLK_DIV - 1);
    localparam logic [PS_W-1:0]  PS_BLANK  = PS_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam bit               HAS_BLANK = (BLANK_CYCLES > 0);

    logic [4*NUM_DIGITS-1:0] value_reg, value_next;
    logic [NUM_DIGITS-1:0]   mask_reg, mask_next;
    logic [PS_W-1:0]         ps_reg, ps_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    frame_reg, frame_next;
    logic [6:0]              seg_n_reg, seg_n_next;
    logic [NUM_DIGITS-1:0]   digit_n_reg, digit_n_next;

    logic [3:0]            nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            sel_nibble;
    logic                  sel_dark;
    logic                  in_blank;
    logic [6:0]            seg_on;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
            assign nibble[gi] = value_reg[4*gi +: 4];
        end
    endgenerate

`ifdef HEX_SCAN_LZ_BLANK_EN
    // upper_zero[i]: nibble i and every nibble above it are zero
    logic [NUM_DIGITS-1:0] upper_zero;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign upper_zero[gi] = (nibble[gi] == 4'h0);
            end else begin : g_mid
                assign upper_zero[gi] = (nibble[gi] == 4'h0) && upper_zero[gi+1];
            end
            assign lz_blank[gi] = (gi != 0) && upper_zero[gi];
        end
    endgenerate
`else
    assign lz_blank = '0;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b1111110;
            4'h1: pat = 7'b0110000;
            4'h2: pat = 7'b1101101;
            4'h3: pat = 7'b1111001;
            4'h4: pat = 7'b0110011;
            4'h5: pat = 7'b1011011;
            4'h6: pat = 7'b1011111;
            4'h7: pat = 7'b1110000;
            4'h8: pat = 7'b1111111;
            4'h9: pat = 7'b1111011;
            4'hA: pat = 7'b1110111;
            4'hB: pat = 7'b0011111;
            4'hC: pat = 7'b1001110;
            4'hD: pat = 7'b0111101;
            4'hE: pat = 7'b1001111;
            default: pat = 7'b1000111;
        endcase
        return pat;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg   <= '0;
            mask_reg    <= '0;
            ps_reg      <= '0;
            idx_reg     <= '0;
            frame_reg   <= 1'b0;
            seg_n_reg   <= 7'b1111111;
            digit_n_reg <= '1;
        end else begin
            value_reg   <= value_next;
            mask_reg    <= mask_next;
            ps_reg      <= ps_next;
            idx_reg     <= idx_next;
            frame_reg   <= frame_next;
            seg_n_reg   <= seg_n_next;
            digit_n_reg <= digit_n_next;
        end
    end

    always_comb begin
        ps_next    = ps_reg;
        idx_next   = idx_reg;
        frame_next = 1'b0;
        value_next = value_reg;
        mask_next  = mask_reg;
        if (ps_reg == PS_LAST) begin
            ps_next = '0;
            if (idx_reg == IDX_LAST) begin
                idx_next   = '0;
                frame_next = 1'b1;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end else begin
            ps_next = ps_reg + 1'b1;
        end
        if (bus.load) begin
            value_next = bus.value;
            mask_next  = bus.blank_mask;
        end
    end

    // Outputs are decoded from the current state, so segment and enable
    // always move together on the same edge.
    always_comb begin
        sel_nibble = 4'h0;
        sel_dark   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sel_nibble = nibble[i];
                sel_dark   = mask_reg[i] | lz_blank[i];
            end
        end
        in_blank = HAS_BLANK && (ps_reg < PS_BLANK);
        seg_on   = glyph(sel_nibble);
        seg_n_next = sel_dark ? 7'b1111111 : ~seg_on;
        digit_n_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!in_blank && !sel_dark && (idx_reg == IDX_W'(i))) begin
                digit_n_next[i] = 1'b0;
            end
        end
    end

    assign bus.seg_n   = seg_n_reg;
    assign bus.digit_n = digit_n_reg;
    assign bus.frame   = frame_reg;
endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display (4 digits, CLK_DIV=4, BLANK_CYCLES=1):
// stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_hex_scan_display;
    logic clk = 1'b0;
    logic reset;

    hex_scan_if #(.NUM_DIGITS(4)) bus_if ();

    hex_scan_display #(
        .NUM_DIGITS(4),
        .CLK_DIV(4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       fr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   mon_cyc = 0;

    // Reference state after the most recent edge
    int          m_ps, m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_mask;

    // Hand-inverted active-low patterns
    function automatic logic [6:0] glyph_n(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h01;
            4'h1: return 7'h4F;
            4'h2: return 7'h12;
            4'h3: return 7'h06;
            4'h4: return 7'h4C;
            4'h5: return 7'h24;
            4'h6: return 7'h20;
            4'h7: return 7'h0F;
            4'h8: return 7'h00;
            4'h9: return 7'h04;
            4'hA: return 7'h08;
            4'hB: return 7'h60;
            4'hC: return 7'h31;
            4'hD: return 7'h42;
            4'hE: return 7'h30;
            default: return 7'h38;
        endcase
    endfunction

    function automatic exp_t model_out(input int ps, input int idx,
                                       input logic [15:0] val, input logic [3:0] msk);
        exp_t       r;
        logic       dark;
        logic [3:0] nib;
        logic [3:0] one_hot;
        one_hot = 4'b0001;
        nib  = val[idx*4 +: 4];
        dark = msk[idx];
`ifdef HEX_SCAN_LZ_BLANK_EN
        if (idx != 0 && (val >> (4*idx)) == 16'h0) dark = 1'b1;
`endif
        r.seg = dark ? 7'h7F : glyph_n(nib);
        r.dig = (ps < 1 || dark) ? 4'hF : ~(one_hot << idx);
        r.fr  = 1'b0;
        return r;
    endfunction

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        if (reset) begin
            e = '{seg: 7'h7F, dig: 4'hF, fr: 1'b0};
            m_ps = 0; m_idx = 0; m_val = 16'h0; m_mask = 4'h0;
        end else begin
            e = model_out(m_ps, m_idx, m_val, m_mask);
            e.fr = (m_ps == 3 && m_idx == 3);
            if (m_ps == 3) begin
                m_ps  = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_ps++;
            end
            if (bus_if.load) begin
                m_val  = bus_if.value;
                m_mask = bus_if.blank_mask;
            end
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic load_value(input logic [15:0] v, input logic [3:0] m);
        bus_if.value      = v;
        bus_if.blank_mask = m;
        bus_if.load       = 1'b1;
        cycle();
        bus_if.load       = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            mon_cyc++;
            tests++;
            if (bus_if.seg_n !== e.seg || bus_if.digit_n !== e.dig || bus_if.frame !== e.fr) begin
                fails++;
                $display("FAIL scan cyc %0d got seg_n=%b digit_n=%b frame=%b exp seg_n=%b digit_n=%b frame=%b",
                         mon_cyc, bus_if.seg_n, bus_if.digit_n, bus_if.frame, e.seg, e.dig, e.fr);
            end else begin
                $display("[TB] cyc %0d seg_n=%b digit_n=%b frame=%b ok",
                         mon_cyc, bus_if.seg_n, bus_if.digit_n, bus_if.frame);
            end
        end
    end

    initial begin
        int t;
        reset             = 1'b1;
        bus_if.value      = 16'h0;
        bus_if.blank_mask = 4'h0;
        bus_if.load       = 1'b0;
        m_ps = 0; m_idx = 0; m_val = 16'h0; m_mask = 4'h0;
        run(2);
        reset = 1'b0;

        // Four-digit scan of 12AF with frame pulses
        load_value(16'h12AF, 4'h0);
        run(40);

        // Every nibble value on digit 0
        for (int v = 0; v < 16; v++) begin
            load_value(16'(v), 4'h0);
            run(15);
        end

        // Masked digit 2
        load_value(16'h00C3, 4'b0100);
        run(20);

        // Load in the middle of digit 1's slot
        load_value(16'h1111, 4'h0);
        t = 0;
        while (!(m_idx == 1 && m_ps == 1) && t < 40) begin
            cycle();
            t++;
        end
        load_value(16'h5555, 4'h0);
        run(12);

        // Reset during digit 2
        t = 0;
        while (!(m_idx == 2 && m_ps == 2) && t < 40) begin
            cycle();
            t++;
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(10);

        // Reset coinciding with a load: reset wins
        bus_if.value = 16'hFFFF;
        bus_if.load  = 1'b1;
        reset        = 1'b1;
        cycle();
        reset        = 1'b0;
        bus_if.load  = 1'b0;
        run(18);

`ifdef HEX_SCAN_LZ_BLANK_EN
        load_value(16'h0070, 4'h0);
        run(18);
        load_value(16'h0000, 4'h0);
        run(18);
`endif

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0 pending", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
